lap_record_store: RTL and testbench

Lap-time record memory for the digital stopwatch: the responder side of the record/recall path driven by the key controller. It accepts 24-bit BCD lap values on a four-phase write handshake and stores them in a circular buffer. On a four-phase read handshake it returns stored laps one at a time, oldest first, wrapping back to the oldest after the newest. It sits between the key controller and the display multiplexer and replaces the external single-port RAM on that path.

---
 rtl/lap_record_store_if.sv | 28 ++
 rtl/lap_record_store.sv | 167 ++++++++++++++++
 tb/tb_lap_record_store.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lap_record_store_if.sv
// Record/recall bus between the key controller (master) and the lap record store (slave).
interface lap_record_store_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned AW     = 3
);
  logic              clr;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic              ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [AW-1:0]     rd_index;
  logic [AW:0]       count;
  logic              empty;
  logic              full;
  logic              wr_err;

  modport master (
    output clr, wr_req, wr_data, rd_req,
    input  ack, rd_data, rd_valid, rd_index, count, empty, full, wr_err
  );

  modport slave (
    input  clr, wr_req, wr_data, rd_req,
    output ack, rd_data, rd_valid, rd_index, count, empty, full, wr_err
  );
endinterface

// File: rtl/lap_record_store.sv
// Circular lap-time record memory with four-phase write/read handshakes.
// Optional LAP_OVERWRITE_EN: a write when full replaces the oldest record instead of being rejected.
module lap_record_store #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  lap_record_store_if.slave bus
);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     rd_off_q, rd_off_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [AW-1:0]     rd_index_q, rd_index_d;
  logic              wr_err_q, wr_err_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     wr_addr;
  logic              full_now;

  // DEPTH is a power of two, so pointer arithmetic wraps for free
  assign rd_addr  = head_q + rd_off_q;
  assign wr_addr  = head_q + AW'(count_q);
  assign full_now = (count_q == DEPTH_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      wdat_q     <= '0;
      head_q     <= '0;
      rd_off_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
      wr_err_q   <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      wdat_q     <= wdat_d;
      head_q     <= head_d;
      rd_off_q   <= rd_off_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
      wr_err_q   <= wr_err_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  // Record storage; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wdat_q;
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    wdat_d     = wdat_q;
    head_d     = head_q;
    rd_off_d   = rd_off_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_index_d = rd_index_q;
    wr_err_d   = wr_err_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;

    case (state_q)
      IDLE: begin
        wr_err_d = 1'b0;
        if (bus.wr_req) begin
          state_d = WR;
          is_wr_d = 1'b1;
          wdat_d  = bus.wr_data;
        end else if (bus.rd_req) begin
          state_d = RD;
          is_wr_d = 1'b0;
        end
      end
      WR: begin
        state_d = DONE;
        if (!full_now) begin
          mem_we   = 1'b1;
          count_d  = count_q + CW'(1);
          rd_off_d = '0;
        end else begin
`ifdef LAP_OVERWRITE_EN
          mem_we    = 1'b1;
          mem_waddr = head_q;
          head_d    = head_q + AW'(1);
          rd_off_d  = '0;
`else
          wr_err_d  = 1'b1;
`endif
        end
      end
      RD: begin
        state_d = DONE;
        if (count_q != '0) begin
          rd_data_d  = mem[rd_addr];
          rd_index_d = rd_off_q;
          rd_valid_d = 1'b1;
          rd_off_d   = (({1'b0, rd_off_q} + CW'(1)) == count_q) ? '0 : rd_off_q + AW'(1);
        end
      end
      DONE: begin
        // only the request that opened the transaction can close it
        if (!(is_wr_q ? bus.wr_req : bus.rd_req)) begin
          state_d  = IDLE;
          wr_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.clr) begin
      state_d    = IDLE;
      head_d     = '0;
      rd_off_d   = '0;
      count_d    = '0;
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
      rd_index_d = '0;
      wr_err_d   = 1'b0;
      mem_we     = 1'b0;
    end

    ack_d   = (state_d == DONE);
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  assign bus.ack      = ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_index = rd_index_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_lap_record_store.sv
// Randomized self-checking bench for lap_record_store against a queue-based record model.
module tb_lap_record_store;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lap_record_store_if #(.DATA_W(DATA_W), .AW(AW)) bus ();
  lap_record_store #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: records oldest-first in a queue, plus the read cursor and last read result
  logic [DATA_W-1:0] mq[$];
  int unsigned       m_ptr;
  logic [DATA_W-1:0] m_last;
  int unsigned       m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ptr  = 0;
    m_last = '0;
    m_idx  = 0;
  endtask

  task automatic model_write(input logic [DATA_W-1:0] d, output logic err);
    err = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
    else begin
`ifdef LAP_OVERWRITE_EN
      void'(mq.pop_front());
      mq.push_back(d);
`else
      err = 1'b1;
`endif
    end
    if (!err) m_ptr = 0;
  endtask

  task automatic model_read(output logic hit);
    hit = (mq.size() > 0);
    if (hit) begin
      m_last = mq[m_ptr];
      m_idx  = m_ptr;
      m_ptr  = (m_ptr + 1) % mq.size();
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(mq.size()));
    check({tag, "_empty"}, 32'(bus.empty), 32'(mq.size() == 0));
    check({tag, "_full"},  32'(bus.full),  32'(mq.size() == DEPTH));
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 10);
  endtask

  task automatic check_read(input logic hit);
    check("rd_valid", 32'(bus.rd_valid), 32'(hit));
    check("rd_data",  32'(bus.rd_data),  32'(m_last));
    check("rd_index", 32'(bus.rd_index), m_idx);
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d);
    logic err;
    int   n;
    model_write(d, err);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    wait_ack(n);
    check("wr_ack_lat", 32'(n), 32'd2);
    check("wr_err", 32'(bus.wr_err), 32'(err));
    check_status("wr");
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", 32'(bus.ack), 32'd0);
    check("wr_err_drop", 32'(bus.wr_err), 32'd0);
  endtask

  task automatic do_read();
    logic hit;
    int   n;
    model_read(hit);
    @(negedge clk);
    bus.rd_req = 1'b1;
    wait_ack(n);
    check("rd_ack_lat", 32'(n), 32'd2);
    check_read(hit);
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("rd_ack_drop", 32'(bus.ack), 32'd0);
    check("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
    check_status("clr");
    check("clr_rd_data", 32'(bus.rd_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic hit;
    logic err;
    int   n;
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ack",      32'(bus.ack),      32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_index", 32'(bus.rd_index), 32'd0);
    check("rst_wr_err",   32'(bus.wr_err),   32'd0);
    check_status("rst");
    rst = 1'b0;

    do_write(24'h000123);
    do_write(24'h000456);
    do_write(24'h000789);
    repeat (4) do_read();

    // empty read keeps rd_data at 0 without rd_valid
    do_clr();
    do_read();

    // fill beyond capacity, then walk all records
    for (int i = 1; i <= 9; i++) do_write(DATA_W'(i));
    for (int i = 0; i < 9; i++) do_read();

    // simultaneous requests: write first, read afterwards returns oldest
    do_clr();
    do_write(24'h000010);
    do_write(24'h000020);
    model_write(24'h000030, err);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    bus.wr_data = 24'h000030;
    wait_ack(n);
    check("both_wr_lat", 32'(n), 32'd2);
    check("both_rd_valid_during_wr", 32'(bus.rd_valid), 32'd0);
    check_status("both");
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("both_ack_drop", 32'(bus.ack), 32'd0);
    model_read(hit);
    wait_ack(n);
    check("both_rd_lat", 32'(n), 32'd2);
    check_read(hit);
    bus.rd_req = 1'b0;
    @(negedge clk);

    // clr while a read sits in DONE
    @(negedge clk);
    bus.rd_req = 1'b1;
    wait_ack(n);
    check("clr_done_lat", 32'(n), 32'd2);
    bus.clr    = 1'b1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
    check("clr_done_ack",      32'(bus.ack),      32'd0);
    check("clr_done_rd_data",  32'(bus.rd_data),  32'd0);
    check("clr_done_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("clr_done_rd_index", 32'(bus.rd_index), 32'd0);
    check_status("clr_done");

    // asynchronous reset in the middle of a write: nothing committed
    do_write(24'h000005);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_data = 24'h000777;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check("rstwr_ack", 32'(bus.ack), 32'd0);
    check_status("rstwr_async");
    @(negedge clk);
    rst        = 1'b0;
    bus.wr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rstwr_ack_after", 32'(bus.ack), 32'd0);
    check_status("rstwr_after");
    do_read();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 9)       do_write(DATA_W'($urandom));
      else if (r < 18) do_read();
      else             do_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
